// File: rtl/arbitro_paralelo_serial_if.sv
// Bus between the byte sources, the lane arbiter and the paralelo_serial serializer.
// master = arbiter side, slave = sources/serializer side.
interface arbitro_paralelo_serial_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_req;
  logic [NUM_REQ-1:0]        pop;
  logic [DATA_W-1:0]         data_ps;
  logic                      valid_ps;
  logic [GID_W-1:0]          grant_id;
  logic                      sync_done;
  logic                      busy;

  modport master (
    input  req, data_req,
    output pop, data_ps, valid_ps, grant_id, sync_done, busy
  );

  modport slave (
    output req, data_req,
    input  pop, data_ps, valid_ps, grant_id, sync_done, busy
  );
endinterface

// File: rtl/arbitro_paralelo_serial.sv
// Round-robin burst arbiter feeding the single paralelo_serial lane from NUM_REQ byte sources.
// Define ARB_STRICT_PRIO_EN for lowest-index-first selection instead of round-robin.
//
// state    | meaning
// ST_SYNC  | post-reset idle window, serializer sends idle/COM symbols
// ST_IDLE  | dead cycle between grants (becomes a COM delimiter), selects next owner
// ST_GRANT | owner pops up to MAX_BURST bytes while its req stays high
module arbitro_paralelo_serial #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_CYCLES = 4,
  parameter int MAX_BURST   = 4
) (
  input  logic                      clk_4f,
  input  logic                      reset_L,
  arbitro_paralelo_serial_if.master bus
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SC_W  = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
  localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_GRANT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SC_W-1:0]     r_sync_cnt;
  logic [GID_W-1:0]    r_owner;
  logic [BC_W-1:0]     r_burst_cnt;
  logic [DATA_W-1:0]   r_data_ps;
  logic                r_valid_ps;
  logic                r_sync_done;
  logic                w_found;
  logic [GID_W-1:0]    w_sel;
  logic [NUM_REQ-1:0]  w_pop;
  logic                w_take;
  logic                w_exit;
  logic [DATA_W-1:0]   w_byte;

`ifdef ARB_STRICT_PRIO_EN
  always_comb begin : p_select
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_found = 1'b1;
        w_sel   = GID_W'(i);
      end
    end
  end
`else
  logic [GID_W-1:0] r_ptr;

  // First requester at or after r_ptr, wrapping at NUM_REQ.
  always_comb begin : p_select
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_sel   = GID_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_ptr <= '0;
    end else if (w_exit) begin
      r_ptr <= (r_owner == GID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    end
  end
`endif

  assign w_byte = bus.data_req[int'(r_owner)*DATA_W +: DATA_W];

  always_comb begin : p_fsm
    w_state_nxt = r_state;
    w_pop       = '0;
    w_take      = 1'b0;
    w_exit      = 1'b0;
    unique case (r_state)
      ST_SYNC: begin
        if (r_sync_cnt == SC_W'(SYNC_CYCLES - 1)) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (bus.req[r_owner]) begin
          w_take         = 1'b1;
          w_pop[r_owner] = 1'b1;
          if (r_burst_cnt == BC_W'(MAX_BURST - 1)) w_exit = 1'b1;
        end else begin
          w_exit = 1'b1;
        end
        if (w_exit) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) r_state <= ST_SYNC;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_sync_cnt  <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_data_ps   <= '0;
      r_valid_ps  <= 1'b0;
      r_sync_done <= 1'b0;
    end else begin
      r_valid_ps <= w_take;
      if (w_take) r_data_ps <= w_byte;
      unique case (r_state)
        ST_SYNC: begin
          if (r_sync_cnt == SC_W'(SYNC_CYCLES - 1)) r_sync_done <= 1'b1;
          else                                      r_sync_cnt  <= r_sync_cnt + 1'b1;
        end
        ST_IDLE: begin
          if (w_found) begin
            r_owner     <= w_sel;
            r_burst_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_exit)      r_burst_cnt <= '0;
          else if (w_take) r_burst_cnt <= r_burst_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pop       = w_pop;
  assign bus.data_ps   = r_data_ps;
  assign bus.valid_ps  = r_valid_ps;
  assign bus.grant_id  = r_owner;
  assign bus.sync_done = r_sync_done;
  assign bus.busy      = (r_state == ST_GRANT);
endmodule
